counter: RTL and testbench

- Parameterised up/down counter with programmable step, synchronous clear and parallel load.
- Used by the matrix-op sequencing FSM as read/write element pointers (step 1), block pointer (step = SINGLE_ACCESS = 8) and compute-cycle counter (3-bit).
- Provides a registered wrap flag so the controller can detect modulo roll-over.

---
 rtl/counter.sv | 60 ++++++
 tb/tb_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Parameterised up/down counter with programmable step, synchronous clear,
// parallel load and a registered single-cycle wrap (carry/borrow) flag.
module counter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] Q,
    output logic             wrap
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // The extra MSB of each result is the carry (up) or borrow (down).
    assign sum  = {1'b0, count_q} + STEP_EXT;
    assign diff = {1'b0, count_q} - STEP_EXT;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = D;
        end else if (en) begin
            if (up) begin
                count_d = sum[WIDTH-1:0];
                wrap_d  = sum[WIDTH];
            end else begin
                count_d = diff[WIDTH-1:0];
                wrap_d  = diff[WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Q    = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: three instances (12-bit step 1, 12-bit step 8,
// 3-bit step 1) share control inputs; each task checks the relevant instance.
module tb_counter;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        load;
    logic        en;
    logic        up;
    logic [11:0] d12;
    logic [2:0]  d3;
    logic [11:0] qa, qb;
    logic [2:0]  qc;
    logic        wa, wb, wc;

    int tests_run;
    int tests_failed;

    counter #(12, 1) u_a (
        .clock(clk), .reset(rst_n), .clear(clear), .load(load), .D(d12),
        .en(en), .up(up), .Q(qa), .wrap(wa)
    );
    counter #(12, 8) u_b (
        .clock(clk), .reset(rst_n), .clear(clear), .load(load), .D(d12),
        .en(en), .up(up), .Q(qb), .wrap(wb)
    );
    counter #(3, 1) u_c (
        .clock(clk), .reset(rst_n), .clear(clear), .load(load), .D(d3),
        .en(en), .up(up), .Q(qc), .wrap(wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); d12 = '0; d3 = '0;
        step();
        rst_n = 1'b1;
        en = 1'b1; up = 1'b1;
        step(); step(); step();
        // Assert reset mid-cycle; outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (qa !== 12'd0 || wa !== 1'b0 || qb !== 12'd0 || qc !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_async: qa=%0d wa=%0b qb=%0d qc=%0d, required all 0", qa, wa, qb, qc);
        end else $display("[TB] reset_async ok qa=%0d", qa);
        step();
        tests_run++;
        if (qa !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: qa=%0d, required 0", qa);
        end else $display("[TB] reset_hold ok qa=%0d", qa);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (qa !== 12'd5 || qb !== 12'd40 || qc !== 3'd5) begin
            tests_failed++;
            $display("FAIL reset_count5: qa=%0d qb=%0d qc=%0d, required 5 40 5", qa, qb, qc);
        end else $display("[TB] reset_count5 ok qa=%0d qb=%0d", qa, qb);
    endtask

    task automatic test_step8();
        logic [11:0] exp;
        idle(); clear = 1'b1;
        step();
        idle(); en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = 12'(8 * i);
            tests_run++;
            if (qb !== exp || wb !== 1'b0) begin
                tests_failed++;
                $display("FAIL step8_%0d: qb=%0d wb=%0b, required %0d 0", i, qb, wb, exp);
            end else $display("[TB] step8_%0d ok qb=%0d", i, qb);
        end
        load = 1'b1; d12 = 12'd0;
        step();
        tests_run++;
        if (qb !== 12'd0) begin
            tests_failed++;
            $display("FAIL load_beats_en: qb=%0d, required 0", qb);
        end else $display("[TB] load_beats_en ok qb=%0d", qb);
    endtask

    task automatic test_wrap3();
        idle(); load = 1'b1; d3 = 3'd6;
        step();
        idle(); en = 1'b1; up = 1'b1;
        step();
        tests_run++;
        if (qc !== 3'd7 || wc !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap3_7: qc=%0d wc=%0b, required 7 0", qc, wc);
        end else $display("[TB] wrap3_7 ok qc=%0d wc=%0b", qc, wc);
        step();
        tests_run++;
        if (qc !== 3'd0 || wc !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap3_0: qc=%0d wc=%0b, required 0 1", qc, wc);
        end else $display("[TB] wrap3_0 ok qc=%0d wc=%0b", qc, wc);
        step();
        tests_run++;
        if (qc !== 3'd1 || wc !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap3_1: qc=%0d wc=%0b, required 1 0", qc, wc);
        end else $display("[TB] wrap3_1 ok qc=%0d wc=%0b", qc, wc);
    endtask

    task automatic test_down();
        idle(); clear = 1'b1;
        step();
        idle(); en = 1'b1; up = 1'b0;
        step();
        tests_run++;
        if (qa !== 12'd4095 || wa !== 1'b1 || qb !== 12'd4088 || wb !== 1'b1) begin
            tests_failed++;
            $display("FAIL down_borrow: qa=%0d wa=%0b qb=%0d wb=%0b, required 4095 1 4088 1", qa, wa, qb, wb);
        end else $display("[TB] down_borrow ok qa=%0d qb=%0d", qa, qb);
        idle();
        step();
        tests_run++;
        if (qa !== 12'd4095 || wa !== 1'b0) begin
            tests_failed++;
            $display("FAIL down_hold: qa=%0d wa=%0b, required 4095 0", qa, wa);
        end else $display("[TB] down_hold ok qa=%0d wa=%0b", qa, wa);
        en = 1'b1; up = 1'b0;
        step();
        tests_run++;
        if (qa !== 12'd4094 || wa !== 1'b0) begin
            tests_failed++;
            $display("FAIL down_plain: qa=%0d wa=%0b, required 4094 0", qa, wa);
        end else $display("[TB] down_plain ok qa=%0d", qa);
    endtask

    task automatic test_priority();
        idle(); load = 1'b1; d12 = 12'd100;
        step();
        tests_run++;
        if (qa !== 12'd100) begin
            tests_failed++;
            $display("FAIL prio_load100: qa=%0d, required 100", qa);
        end else $display("[TB] prio_load100 ok qa=%0d", qa);
        clear = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; d12 = 12'd55;
        step();
        tests_run++;
        if (qa !== 12'd0 || wa !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_clear: qa=%0d wa=%0b, required 0 0", qa, wa);
        end else $display("[TB] prio_clear ok qa=%0d", qa);
        idle(); load = 1'b1;
        step();
        tests_run++;
        if (qa !== 12'd55) begin
            tests_failed++;
            $display("FAIL prio_load55: qa=%0d, required 55", qa);
        end else $display("[TB] prio_load55 ok qa=%0d", qa);
        idle();
        step();
        tests_run++;
        if (qa !== 12'd55 || wa !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_idle: qa=%0d wa=%0b, required 55 0", qa, wa);
        end else $display("[TB] prio_idle ok qa=%0d", qa);
    endtask

    task automatic test_residue();
        idle(); load = 1'b1; d12 = 12'd4090;
        step();
        idle(); en = 1'b1; up = 1'b1;
        step();
        tests_run++;
        if (qb !== 12'd2 || wb !== 1'b1) begin
            tests_failed++;
            $display("FAIL residue_4090: qb=%0d wb=%0b, required 2 1", qb, wb);
        end else $display("[TB] residue_4090 ok qb=%0d wb=%0b", qb, wb);
        idle();
        for (int i = 0; i < 3; i++) begin
            up = ~up;
            step();
        end
        tests_run++;
        if (qb !== 12'd2 || wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL up_ignored: qb=%0d wb=%0b, required 2 0", qb, wb);
        end else $display("[TB] up_ignored ok qb=%0d", qb);
        load = 1'b1; d12 = 12'd4095;
        step();
        idle(); en = 1'b1; up = 1'b1;
        step();
        tests_run++;
        if (qb !== 12'd7 || wb !== 1'b1) begin
            tests_failed++;
            $display("FAIL residue_4095: qb=%0d wb=%0b, required 7 1", qb, wb);
        end else $display("[TB] residue_4095 ok qb=%0d wb=%0b", qb, wb);
    endtask

    task automatic test_back_to_back();
        idle(); load = 1'b1; d12 = 12'd4094;
        step();
        idle(); en = 1'b1; up = 1'b1;
        step();
        tests_run++;
        if (qa !== 12'd4095 || wa !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_4095: qa=%0d wa=%0b, required 4095 0", qa, wa);
        end else $display("[TB] b2b_4095 ok qa=%0d", qa);
        up = 1'b0;
        step();
        tests_run++;
        if (qa !== 12'd4094 || wa !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_reverse: qa=%0d wa=%0b, required 4094 0", qa, wa);
        end else $display("[TB] b2b_reverse ok qa=%0d", qa);
        idle();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_step8();
        test_wrap3();
        test_down();
        test_priority();
        test_residue();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
